// File: rtl/vote_tally_if.sv
// -----------------------------------------------------------------------------
// vote_tally_if
// Ballot handshake bundle between a ballot source and the vote_tally block.
//   vote_valid  : source -> tally, ballot present
//   vote_ready  : tally -> source, ballot accepted this cycle when valid
//   vote_id     : source -> tally, voter ID
//   vote_sel    : source -> tally, one-hot candidate choice
//   vote_reject : tally -> source, pulse one cycle after a discarded ballot
// Modports: master = ballot source, slave = vote_tally.
// -----------------------------------------------------------------------------
interface vote_tally_if #(
  parameter int NUM_CAND = 3,
  parameter int VID_W    = 3
);
  logic                vote_valid;
  logic                vote_ready;
  logic                vote_reject;
  logic [VID_W-1:0]    vote_id;
  logic [NUM_CAND-1:0] vote_sel;

  modport master (
    output vote_valid, vote_id, vote_sel,
    input  vote_ready, vote_reject
  );

  modport slave (
    input  vote_valid, vote_id, vote_sel,
    output vote_ready, vote_reject
  );
endinterface

// File: rtl/vote_tally.sv
// -----------------------------------------------------------------------------
// vote_tally
// Serial ballot collector and decider. Ballots arrive over vote_bus, are
// checked (one-hot choice, legal voter ID, not already voted), tallied per
// candidate, and after all voters have voted or close is seen, the winner,
// tie and no-majority flags are computed and held until the next election.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : open a new election (IDLE/DONE only)
//   majority_mode  : 1 = strict majority, 0 = plurality; latched on start
//   close          : end collection early
//   vote_bus       : ballot handshake (slave side)
//   busy           : election collecting or deciding
//   vote_count     : accepted ballots in current election
//   result_valid   : winner/tie/no_majority are valid
//   winner         : one-hot winner, zero if none
//   tie            : several candidates share the nonzero maximum
//   no_majority    : majority mode and the unique leader lacks a majority
// All outputs are registered.
// -----------------------------------------------------------------------------
module vote_tally #(
  parameter int NUM_CAND   = 3,
  parameter int NUM_VOTERS = 5,
  parameter int VID_W      = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              majority_mode,
  input  logic                              close,
  vote_tally_if.slave                       vote_bus,
  output logic                              busy,
  output logic [$clog2(NUM_VOTERS+1)-1:0]   vote_count,
  output logic                              result_valid,
  output logic [NUM_CAND-1:0]               winner,
  output logic                              tie,
  output logic                              no_majority
);

  localparam int CNT_W  = $clog2(NUM_VOTERS + 1);
  localparam int HOLD_W = $clog2(NUM_CAND + 1);
  localparam int MASK_W = 2 ** VID_W;

  localparam logic [CNT_W-1:0] NV_CNT = CNT_W'(NUM_VOTERS);
  localparam logic [CNT_W:0]   NV_X2  = (CNT_W+1)'(NUM_VOTERS);
  localparam logic [VID_W:0]   NV_ID  = (VID_W+1)'(NUM_VOTERS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DECIDE  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                         state_q,  state_d;
  logic [NUM_CAND-1:0][CNT_W-1:0] tally_q,  tally_d;
  // Mask spans every encodable ID so out-of-range IDs index safely.
  logic [MASK_W-1:0]              mask_q,   mask_d;
  logic [CNT_W-1:0]               count_q,  count_d;
  logic                           mode_q,   mode_d;
  logic                           reject_q, reject_d;
  logic [NUM_CAND-1:0]            winner_q, winner_d;
  logic                           tie_q,    tie_d;
  logic                           nomaj_q,  nomaj_d;
  logic                           rvalid_q, rvalid_d;
  logic                           ready_q;
  logic                           busy_q;

  logic                           handshake_s;
  logic                           legal_s;
  logic [CNT_W-1:0]               max_s;
  logic [NUM_CAND-1:0]            leader_s;
  logic [HOLD_W-1:0]              nhold_s;
  logic [CNT_W:0]                 twice_max_s;

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [NUM_CAND-1:0] v);
    return (v != {NUM_CAND{1'b0}}) &&
           ((v & (v - {{(NUM_CAND-1){1'b0}}, 1'b1})) == {NUM_CAND{1'b0}});
  endfunction

  assign handshake_s = vote_bus.vote_valid & ready_q;
  assign legal_s     = is_onehot(vote_bus.vote_sel) &&
                       ({1'b0, vote_bus.vote_id} < NV_ID) &&
                       !mask_q[vote_bus.vote_id];

  // Maximum tally, which candidates hold it, and how many do.
  always_comb begin
    max_s    = {CNT_W{1'b0}};
    leader_s = {NUM_CAND{1'b0}};
    nhold_s  = {HOLD_W{1'b0}};
    for (int c = 0; c < NUM_CAND; c++) begin
      if (tally_q[c] > max_s) begin
        max_s = tally_q[c];
      end else begin
        max_s = max_s;
      end
    end
    for (int c = 0; c < NUM_CAND; c++) begin
      leader_s[c] = (tally_q[c] == max_s);
      nhold_s     = nhold_s + HOLD_W'(leader_s[c]);
    end
    twice_max_s = {max_s, 1'b0};
  end

  // Next-state and next-register logic for the election FSM.
  always_comb begin
    state_d  = state_q;
    tally_d  = tally_q;
    mask_d   = mask_q;
    count_d  = count_q;
    mode_d   = mode_q;
    reject_d = 1'b0;
    winner_d = winner_q;
    tie_d    = tie_q;
    nomaj_d  = nomaj_q;
    rvalid_d = rvalid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_COLLECT;
          tally_d  = {(NUM_CAND*CNT_W){1'b0}};
          mask_d   = {MASK_W{1'b0}};
          count_d  = {CNT_W{1'b0}};
          mode_d   = majority_mode;
          winner_d = {NUM_CAND{1'b0}};
          tie_d    = 1'b0;
          nomaj_d  = 1'b0;
          rvalid_d = 1'b0;
        end else begin
          state_d  = state_q;
        end
      end

      S_COLLECT: begin
        if (handshake_s) begin
          if (legal_s) begin
            for (int c = 0; c < NUM_CAND; c++) begin
              if (vote_bus.vote_sel[c]) begin
                tally_d[c] = tally_q[c] + {{(CNT_W-1){1'b0}}, 1'b1};
              end else begin
                tally_d[c] = tally_q[c];
              end
            end
            mask_d[vote_bus.vote_id] = 1'b1;
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            reject_d = 1'b1;
          end
        end else begin
          reject_d = 1'b0;
        end
        // The ballot accepted this cycle counts toward completion.
        if ((count_d == NV_CNT) || close) begin
          state_d = S_DECIDE;
        end else begin
          state_d = S_COLLECT;
        end
      end

      S_DECIDE: begin
        state_d  = S_DONE;
        rvalid_d = 1'b1;
        if (max_s == {CNT_W{1'b0}}) begin
          winner_d = {NUM_CAND{1'b0}};
          tie_d    = 1'b0;
          nomaj_d  = mode_q;
        end else if (nhold_s > {{(HOLD_W-1){1'b0}}, 1'b1}) begin
          winner_d = {NUM_CAND{1'b0}};
          tie_d    = 1'b1;
          nomaj_d  = 1'b0;
        end else if (mode_q && (twice_max_s <= NV_X2)) begin
          winner_d = {NUM_CAND{1'b0}};
          tie_d    = 1'b0;
          nomaj_d  = 1'b1;
        end else begin
          winner_d = leader_s;
          tie_d    = 1'b0;
          nomaj_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; ready/busy decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tally_q  <= {(NUM_CAND*CNT_W){1'b0}};
      mask_q   <= {MASK_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      mode_q   <= 1'b0;
      reject_q <= 1'b0;
      winner_q <= {NUM_CAND{1'b0}};
      tie_q    <= 1'b0;
      nomaj_q  <= 1'b0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tally_q  <= tally_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      reject_q <= reject_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      nomaj_q  <= nomaj_d;
      rvalid_q <= rvalid_d;
      ready_q  <= (state_d == S_COLLECT);
      busy_q   <= (state_d == S_COLLECT) || (state_d == S_DECIDE);
    end
  end

  assign vote_bus.vote_ready  = ready_q;
  assign vote_bus.vote_reject = reject_q;
  assign busy                 = busy_q;
  assign vote_count           = count_q;
  assign result_valid         = rvalid_q;
  assign winner               = winner_q;
  assign tie                  = tie_q;
  assign no_majority          = nomaj_q;

endmodule

// File: tb/tb_vote_tally.sv
// -----------------------------------------------------------------------------
// tb_vote_tally
// Directed-vector bench for vote_tally with the default parameters
// (3 candidates, 5 voters, 3-bit IDs). Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_vote_tally;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       majority_mode;
  logic       close;
  logic       busy;
  logic [2:0] vote_count;
  logic       result_valid;
  logic [2:0] winner;
  logic       tie;
  logic       no_majority;

  int nvec;
  int nmis;

  vote_tally_if #(.NUM_CAND(3), .VID_W(3)) bus ();

  vote_tally #(.NUM_CAND(3), .NUM_VOTERS(5), .VID_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .majority_mode (majority_mode),
    .close         (close),
    .vote_bus      (bus.slave),
    .busy          (busy),
    .vote_count    (vote_count),
    .result_valid  (result_valid),
    .winner        (winner),
    .tie           (tie),
    .no_majority   (no_majority)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic open_election(input logic mode);
    start         = 1'b1;
    majority_mode = mode;
    step();
    start         = 1'b0;
    chk("open_busy", 32'(busy), 32'd1);
    chk("open_ready", 32'(bus.vote_ready), 32'd1);
    chk("open_count", 32'(vote_count), 32'd0);
    chk("open_rvalid", 32'(result_valid), 32'd0);
  endtask

  task automatic send(input logic [2:0] id, input logic [2:0] sel, input logic cl);
    bus.vote_valid = 1'b1;
    bus.vote_id    = id;
    bus.vote_sel   = sel;
    close          = cl;
    step();
    bus.vote_valid = 1'b0;
    close          = 1'b0;
  endtask

  task automatic close_now();
    close = 1'b1;
    step();
    close = 1'b0;
  endtask

  // Called in the DECIDE cycle; result must appear after one more edge.
  task automatic expect_result(input string tag, input logic [2:0] w,
                               input logic t, input logic nm);
    chk({tag, "_decide_rv"}, 32'(result_valid), 32'd0);
    chk({tag, "_decide_ready"}, 32'(bus.vote_ready), 32'd0);
    step();
    chk({tag, "_rvalid"}, 32'(result_valid), 32'd1);
    chk({tag, "_winner"}, 32'(winner), 32'(w));
    chk({tag, "_tie"}, 32'(tie), 32'(t));
    chk({tag, "_nomaj"}, 32'(no_majority), 32'(nm));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    nvec           = 0;
    nmis           = 0;
    rst_n          = 1'b0;
    start          = 1'b0;
    majority_mode  = 1'b0;
    close          = 1'b0;
    bus.vote_valid = 1'b0;
    bus.vote_id    = 3'd0;
    bus.vote_sel   = 3'd0;

    // Reset state
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.vote_ready), 32'd0);
    chk("rst_count", 32'(vote_count), 32'd0);
    chk("rst_rvalid", 32'(result_valid), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_reject", 32'(bus.vote_reject), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", 32'(bus.vote_ready), 32'd0);

    // Mode 0, unanimous for candidate 0
    open_election(1'b0);
    send(3'd0, 3'b001, 1'b0);
    chk("e1_count1", 32'(vote_count), 32'd1);
    send(3'd1, 3'b001, 1'b0);
    send(3'd2, 3'b001, 1'b0);
    send(3'd3, 3'b001, 1'b0);
    send(3'd4, 3'b001, 1'b0);
    chk("e1_count5", 32'(vote_count), 32'd5);
    chk("e1_busy_decide", 32'(busy), 32'd1);
    expect_result("e1", 3'b001, 1'b0, 1'b0);
    step();
    chk("e1_hold_winner", 32'(winner), 32'd1);
    chk("e1_hold_rvalid", 32'(result_valid), 32'd1);

    // Mode 1, 4 of 5 for candidate 0 -> majority
    open_election(1'b1);
    send(3'd0, 3'b001, 1'b0);
    send(3'd1, 3'b001, 1'b0);
    send(3'd2, 3'b001, 1'b0);
    send(3'd3, 3'b001, 1'b0);
    send(3'd4, 3'b010, 1'b0);
    expect_result("e2", 3'b001, 1'b0, 1'b0);

    // Mode 1, 2-2-1 -> tie
    open_election(1'b1);
    send(3'd0, 3'b100, 1'b0);
    send(3'd1, 3'b100, 1'b0);
    send(3'd2, 3'b010, 1'b0);
    send(3'd3, 3'b010, 1'b0);
    send(3'd4, 3'b001, 1'b0);
    expect_result("e3", 3'b000, 1'b1, 1'b0);

    // Mode 1, 2-1-1 then close -> no majority
    open_election(1'b1);
    send(3'd0, 3'b100, 1'b0);
    send(3'd1, 3'b100, 1'b0);
    send(3'd2, 3'b010, 1'b0);
    send(3'd3, 3'b001, 1'b0);
    chk("e4_count4", 32'(vote_count), 32'd4);
    close_now();
    expect_result("e4", 3'b000, 1'b0, 1'b1);

    // Same ballots, mode 0 -> plurality winner
    open_election(1'b0);
    send(3'd0, 3'b100, 1'b0);
    send(3'd1, 3'b100, 1'b0);
    send(3'd2, 3'b010, 1'b0);
    send(3'd3, 3'b001, 1'b0);
    close_now();
    expect_result("e5", 3'b100, 1'b0, 1'b0);

    // Rejections: duplicate, bad ID, two-hot, zero-hot
    open_election(1'b0);
    send(3'd0, 3'b001, 1'b0);
    chk("rj_ok0", 32'(bus.vote_reject), 32'd0);
    send(3'd2, 3'b010, 1'b0);
    chk("rj_count2", 32'(vote_count), 32'd2);
    send(3'd2, 3'b100, 1'b0);
    chk("rj_dup", 32'(bus.vote_reject), 32'd1);
    chk("rj_dup_count", 32'(vote_count), 32'd2);
    step();
    chk("rj_pulse_end", 32'(bus.vote_reject), 32'd0);
    send(3'd6, 3'b100, 1'b0);
    chk("rj_badid", 32'(bus.vote_reject), 32'd1);
    send(3'd3, 3'b011, 1'b0);
    chk("rj_twohot", 32'(bus.vote_reject), 32'd1);
    send(3'd3, 3'b000, 1'b0);
    chk("rj_zerohot", 32'(bus.vote_reject), 32'd1);
    chk("rj_count_still2", 32'(vote_count), 32'd2);
    send(3'd3, 3'b100, 1'b0);
    chk("rj_accept_after", 32'(bus.vote_reject), 32'd0);
    chk("rj_count3", 32'(vote_count), 32'd3);
    send(3'd4, 3'b100, 1'b0);
    send(3'd1, 3'b100, 1'b0);
    chk("rj_count5", 32'(vote_count), 32'd5);
    // Tallies 1/1/3: a leaked rejected ballot would change this
    expect_result("rj", 3'b100, 1'b0, 1'b0);

    // start during COLLECT ignored; close with 3rd ballot
    open_election(1'b0);
    send(3'd0, 3'b010, 1'b0);
    send(3'd1, 3'b010, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("st_ignored_count", 32'(vote_count), 32'd2);
    chk("st_ignored_busy", 32'(bus.vote_ready), 32'd1);
    send(3'd2, 3'b001, 1'b1);
    chk("cl_count3", 32'(vote_count), 32'd3);
    expect_result("cl", 3'b010, 1'b0, 1'b0);

    // Mode 1 with no ballots -> no_majority, no winner
    open_election(1'b1);
    close_now();
    expect_result("empty", 3'b000, 1'b0, 1'b1);

    // Reset mid-election
    open_election(1'b0);
    send(3'd0, 3'b001, 1'b0);
    send(3'd1, 3'b001, 1'b0);
    chk("mr_count2", 32'(vote_count), 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready", 32'(bus.vote_ready), 32'd0);
    chk("mr_count", 32'(vote_count), 32'd0);
    chk("mr_rvalid", 32'(result_valid), 32'd0);
    chk("mr_winner", 32'(winner), 32'd0);
    step();
    chk("mr_idle_busy", 32'(busy), 32'd0);
    open_election(1'b0);
    send(3'd0, 3'b010, 1'b0);
    chk("mr_new_count1", 32'(vote_count), 32'd1);
    send(3'd1, 3'b010, 1'b0);
    close_now();
    expect_result("mr", 3'b010, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  // Hard stop if something above never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vote_tally.md
Name: vote_tally

Overview:
Sequential, parametrised successor to the combinational 5-voter/3-candidate majority voter. Accepts one-hot ballots serially over a valid/ready handshake, tagged with a voter ID. Rejects malformed and duplicate ballots, tallies per candidate, and reports a one-hot winner with tie and no-majority flags. Sits between a ballot source and downstream result logic; one election runs at a time.

Parameters:
NUM_CAND, 3, number of candidates (one-hot ballot width), >=2
NUM_VOTERS, 5, number of eligible voters, >=1
VID_W, 3, voter ID width; requires 2**VID_W >= NUM_VOTERS
Derived localparam CNT_W = $clog2(NUM_VOTERS+1), per-candidate counter width.

Ports:
clk  in  1  clock; all logic is rising-edge
rst_n  in  1  synchronous active-low reset
start  in  1  opens a new election; sampled only in IDLE or DONE
majority_mode  in  1  1 = strict majority required, 0 = plurality; latched on start
close  in  1  ends collection early; sampled in COLLECT
vote_valid  in  1  ballot present
vote_ready  out  1  block accepts a ballot this cycle
vote_id  in  VID_W  voter ID, legal range 0..NUM_VOTERS-1
vote_sel  in  NUM_CAND  one-hot candidate choice
vote_reject  out  1  one-cycle pulse: previous handshake ballot was discarded
busy  out  1  high in COLLECT and DECIDE
vote_count  out  CNT_W  accepted-ballot count for the current election
result_valid  out  1  result outputs are valid; held until next start or reset
winner  out  NUM_CAND  one-hot winner, all-zero if there is no winner
tie  out  1  two or more candidates share a nonzero maximum
no_majority  out  1  majority_mode and unique leader count*2 <= NUM_VOTERS

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; tallies, voted mask and latched mode cleared; all outputs 0.
- FSM states: IDLE, COLLECT, DECIDE, DONE.
- IDLE: vote_ready=0. start -> COLLECT; clear tallies, mask and vote_count; latch majority_mode.
- COLLECT: vote_ready=1. A handshake is vote_valid & vote_ready.
- A ballot is accepted iff vote_sel is exactly one-hot, vote_id < NUM_VOTERS and the mask bit for vote_id is clear.
- Accepted ballot: increment that candidate's tally, set the mask bit, increment vote_count; all take effect on the next edge.
- Rejected ballot: no state change; vote_reject=1 on the following cycle only.
- Leave COLLECT for DECIDE when vote_count reaches NUM_VOTERS (including via the current accept) or close=1.
- close in the same cycle as a handshake: the ballot is still evaluated and counted if legal.
- start while busy is ignored.
- DECIDE: lasts one cycle, vote_ready=0. Compute max tally M and how many candidates hold M.
  - M==0: winner=0, tie=0, no_majority=latched mode.
  - More than one candidate holds M: winner=0, tie=1, no_majority=0.
  - Unique leader: in mode 1 with 2*M <= NUM_VOTERS, winner=0 and no_majority=1; otherwise winner=that one-hot bit.
  - Register results and enter DONE.
- Latency: last accepted handshake at edge T -> DECIDE during cycle T+1 -> result_valid=1 from T+2.
- DONE: result_valid=1; winner, tie and no_majority held stable; vote_ready=0. start -> COLLECT, clearing results and result_valid on the same edge.
- Counters cannot overflow: the mask bounds each tally and vote_count at NUM_VOTERS.
- rst_n low mid-election aborts immediately; no partial result is produced.

Test Plan:
- Mode 0, IDs 0-4 all vote 001 -> vote_count=5, result_valid 2 cycles after 5th accept, winner=001, tie=0.
- Mode 1, ballots 001,001,001,001,010 -> winner=001. Then start, ballots 100,100,010,010,001 -> winner=000, tie=1.
- Mode 1, ballots 100,100,010,001 then close -> M=2 with 2*2<=5 -> winner=000, no_majority=1. Same ballots in mode 0 -> winner=100.
- Rejection: duplicate vote_id=2, vote_id=6, vote_sel=011, vote_sel=000 -> each gives a vote_reject pulse; vote_count and tallies unchanged; valid ballots still accepted afterwards.
- close asserted with the 3rd legal ballot -> ballot counted, vote_count=3, DECIDE next cycle. start during COLLECT -> ignored.
- rst_n low after 2 accepted ballots -> all outputs 0, state IDLE. New election from start counts from 0.
